// File: rtl/bus_router.sv
// bus_router: single-outstanding transaction controller between the
// arbitrated memory port and NSLV memory-mapped slaves.
//
// Address decode picks the lowest-index slave whose [base, top) window
// contains memory_addr. A hit fires a one-cycle slv_valid pulse in the same
// cycle as memory_valid, and the FSM waits in BUSY for that slave's ready.
// A miss produces a one-cycle error response from the ERR state.
//
// Optional feature macro: BUS_ROUTER_TIMEOUT_EN
//   When defined, BUSY gives up after TIMEOUT_CYC cycles without a ready
//   and returns an error response. When undefined, BUSY waits indefinitely.
//
// Ports:
//   clock, reset                 rising-edge clock, async active-low reset
//   memory_valid/instr/addr/
//   memory_wdata/wstrb           master request (wstrb == 0 means read)
//   memory_rdata/error/ready     master response, ready is a one-cycle pulse
//   slv_valid                    per-slave request pulse (one-hot or zero)
//   slv_instr/addr/wdata/wstrb   broadcast request; slv_addr is the offset
//                                from the selected slave's base
//   slv_rdata, slv_ready         packed slave read data, per-slave ready
//   dbg_state                    FSM state (0 IDLE, 1 BUSY, 2 ERR)
//
// Handshake: memory_valid is a request pulse accepted only in IDLE; exactly
// one memory_ready pulse answers each accepted request. slv_ready is
// honoured only from the selected slave while BUSY; all other slv_ready
// pulses are dropped.

module bus_router #(
   parameter int unsigned          NSLV        = 4,
   parameter logic [32*NSLV-1:0]   SLV_BASE    = {NSLV{32'h0}},
   parameter logic [32*NSLV-1:0]   SLV_TOP     = {NSLV{32'h0}},
   parameter int unsigned          TIMEOUT_CYC = 256
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                memory_valid,
   input  logic                memory_instr,
   input  logic [31:0]         memory_addr,
   input  logic [31:0]         memory_wdata,
   input  logic [3:0]          memory_wstrb,
   output logic [31:0]         memory_rdata,
   output logic                memory_error,
   output logic                memory_ready,
   output logic [NSLV-1:0]     slv_valid,
   output logic                slv_instr,
   output logic [31:0]         slv_addr,
   output logic [31:0]         slv_wdata,
   output logic [3:0]          slv_wstrb,
   input  logic [32*NSLV-1:0]  slv_rdata,
   input  logic [NSLV-1:0]     slv_ready,
   output logic [1:0]          dbg_state
);

   localparam int SELW = (NSLV > 1) ? $clog2(NSLV) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_ERR  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [SELW-1:0]   sel_q, sel_d;

   logic              hit_any;
   logic [SELW-1:0]   hit_idx;
   logic [31:0]       hit_base;
   logic              ready_sel;
   logic [31:0]       rdata_sel;
   logic              timeout_hit;

   // Decode: scan from the top index down so the lowest matching index is
   // the last writer and therefore wins on overlapping windows.
   always_comb begin
      hit_any  = 1'b0;
      hit_idx  = '0;
      hit_base = 32'h0;
      for (int i = NSLV - 1; i >= 0; i--) begin
         if ((memory_addr >= SLV_BASE[32*i +: 32]) &&
             (memory_addr <  SLV_TOP[32*i +: 32])) begin
            hit_any  = 1'b1;
            hit_idx  = SELW'(i);
            hit_base = SLV_BASE[32*i +: 32];
         end
      end
   end

   assign ready_sel = slv_ready[sel_q];
   assign rdata_sel = slv_rdata[32*sel_q +: 32];

   // Broadcast request fields; on a miss hit_base is 0 so slv_addr is the raw address.
   assign slv_instr = memory_instr;
   assign slv_addr  = memory_addr - hit_base;
   assign slv_wdata = memory_wdata;
   assign slv_wstrb = memory_wstrb;
   assign dbg_state = state_q;

`ifdef BUS_ROUTER_TIMEOUT_EN
   localparam int TCW = $clog2(TIMEOUT_CYC + 1);

   logic [TCW-1:0] tcnt_q, tcnt_d;

   // A ready in the final BUSY cycle still wins over the timeout.
   assign timeout_hit = (state_q == ST_BUSY) && !ready_sel &&
                        (tcnt_q == TCW'(TIMEOUT_CYC - 1));

   always_comb begin
      tcnt_d = tcnt_q;
      if (state_q == ST_IDLE && memory_valid && hit_any) begin
         tcnt_d = '0;
      end else if (state_q == ST_BUSY && !ready_sel) begin
         tcnt_d = tcnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tcnt_q <= '0;
      end else begin
         tcnt_q <= tcnt_d;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      case (state_q)
         ST_IDLE: begin
            if (memory_valid) begin
               if (hit_any) begin
                  state_d = ST_BUSY;
                  sel_d   = hit_idx;
               end else begin
                  state_d = ST_ERR;
               end
            end
         end
         ST_BUSY: begin
            if (ready_sel || timeout_hit) begin
               state_d = ST_IDLE;
            end
         end
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output logic; everything is forced quiet while reset is held low.
   always_comb begin
      slv_valid    = '0;
      memory_ready = 1'b0;
      memory_error = 1'b0;
      memory_rdata = 32'h0;
      if (reset) begin
         case (state_q)
            ST_IDLE: begin
               if (memory_valid && hit_any) begin
                  slv_valid[hit_idx] = 1'b1;
               end
            end
            ST_BUSY: begin
               if (ready_sel) begin
                  memory_ready = 1'b1;
                  memory_rdata = rdata_sel;
               end else if (timeout_hit) begin
                  memory_ready = 1'b1;
                  memory_error = 1'b1;
               end
            end
            ST_ERR: begin
               memory_ready = 1'b1;
               memory_error = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_router.sv
module tb_bus_router;

   localparam int NSLV = 2;

   logic             clock;
   logic             reset;
   logic             memory_valid;
   logic             memory_instr;
   logic [31:0]      memory_addr;
   logic [31:0]      memory_wdata;
   logic [3:0]       memory_wstrb;
   logic [31:0]      memory_rdata;
   logic             memory_error;
   logic             memory_ready;
   logic [NSLV-1:0]  slv_valid;
   logic             slv_instr;
   logic [31:0]      slv_addr;
   logic [31:0]      slv_wdata;
   logic [3:0]       slv_wstrb;
   logic [63:0]      slv_rdata;
   logic [NSLV-1:0]  slv_ready;
   logic [1:0]       dbg_state;

   int checks = 0;
   int errors = 0;

   // Expected responses: {error, rdata}
   logic [32:0] exp_q[$];

   bus_router #(
      .NSLV        (NSLV),
      .SLV_BASE    ({32'h0200_0000, 32'h0000_0000}),
      .SLV_TOP     ({32'h0200_0010, 32'h0001_0000}),
      .TIMEOUT_CYC (8)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .memory_valid (memory_valid),
      .memory_instr (memory_instr),
      .memory_addr  (memory_addr),
      .memory_wdata (memory_wdata),
      .memory_wstrb (memory_wstrb),
      .memory_rdata (memory_rdata),
      .memory_error (memory_error),
      .memory_ready (memory_ready),
      .slv_valid    (slv_valid),
      .slv_instr    (slv_instr),
      .slv_addr     (slv_addr),
      .slv_wdata    (slv_wdata),
      .slv_wstrb    (slv_wstrb),
      .slv_rdata    (slv_rdata),
      .slv_ready    (slv_ready),
      .dbg_state    (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Drive a request in the current cycle, check the same-cycle slave side,
   // then drop memory_valid in the next cycle.
   task automatic issue(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic instr,
                        input logic [1:0] exp_sv, input logic [31:0] exp_saddr,
                        input bit push, input logic [32:0] exp_rsp);
      memory_valid = 1'b1;
      memory_addr  = addr;
      memory_wdata = wdata;
      memory_wstrb = wstrb;
      memory_instr = instr;
      if (push) exp_q.push_back(exp_rsp);
      @(negedge clock);
      chk("issue_slv_valid", 64'(slv_valid), 64'(exp_sv));
      chk("issue_slv_addr", 64'(slv_addr), 64'(exp_saddr));
      chk("issue_no_ready", 64'(memory_ready), 64'd0);
      chk("issue_bcast", {31'd0, slv_instr, slv_wdata},
          {31'd0, instr, wdata});
      chk("issue_wstrb", 64'(slv_wstrb), 64'(wstrb));
      step();
      memory_valid = 1'b0;
   endtask

   task automatic respond(input int idx, input logic [31:0] data);
      slv_rdata[32*idx +: 32] = data;
      slv_ready = 2'(1 << idx);
      @(negedge clock);
      chk("respond_ready", 64'(memory_ready), 64'd1);
      step();
      slv_ready = '0;
   endtask

   task automatic err_cycle();
      @(negedge clock);
      chk("err_ready", 64'(memory_ready), 64'd1);
      chk("err_error", 64'(memory_error), 64'd1);
      step();
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clock) begin
      if (reset && memory_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready actual err=%0d rdata=%0h required no response",
                     memory_error, memory_rdata);
         end else begin
            chk("response", {31'd0, memory_error, memory_rdata}, 64'(exp_q.pop_front()));
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      reset        = 1'b0;
      memory_valid = 1'b1;          // held during reset: must not reach a slave
      memory_instr = 1'b0;
      memory_addr  = 32'h0000_0040;
      memory_wdata = 32'h0;
      memory_wstrb = 4'h0;
      slv_rdata    = {32'h5555_5555, 32'hAAAA_AAAA};
      slv_ready    = 2'b01;

      // Reset state
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("rst_slv_valid", 64'(slv_valid), 64'd0);
      chk("rst_ready", 64'(memory_ready), 64'd0);
      chk("rst_error", 64'(memory_error), 64'd0);
      chk("rst_rdata", 64'(memory_rdata), 64'd0);
      chk("rst_state", 64'(dbg_state), 64'd0);
      step();
      reset        = 1'b1;
      memory_valid = 1'b0;
      slv_ready    = '0;
      step();

      // Read slave0, ready three cycles after the request
      issue(32'h0000_0040, 32'h0, 4'h0, 1'b1, 2'b01, 32'h40, 1'b1, {1'b0, 32'hDEAD_BEEF});
      // memory_valid while BUSY is ignored
      memory_valid = 1'b1;
      memory_addr  = 32'h0200_0000;
      @(negedge clock);
      chk("busy_valid_ignored", 64'(slv_valid), 64'd0);
      chk("busy_state", 64'(dbg_state), 64'd1);
      step();
      memory_valid = 1'b0;
      step();
      respond(0, 32'hDEAD_BEEF);
      @(negedge clock);
      chk("read_back_idle", 64'(dbg_state), 64'd0);
      step();

      // Write slave1, ready next cycle
      issue(32'h0200_0004, 32'hCAFE_F00D, 4'hF, 1'b0, 2'b10, 32'h4, 1'b1, {1'b0, 32'hA5A5_0001});
      respond(1, 32'hA5A5_0001);

      // Unmapped access
      slv_rdata = {32'h1234_5678, 32'h8765_4321};
      issue(32'h1000_0000, 32'h0, 4'h0, 1'b0, 2'b00, 32'h1000_0000, 1'b1, {1'b1, 32'h0});
      err_cycle();
      @(negedge clock);
      chk("err_back_idle", 64'(dbg_state), 64'd0);
      chk("err_single_ready", 64'(memory_ready), 64'd0);
      step();

      // Window boundaries
      issue(32'h0000_FFFF, 32'h0, 4'h0, 1'b0, 2'b01, 32'h0000_FFFF, 1'b1, {1'b0, 32'h1111_2222});
      respond(0, 32'h1111_2222);
      issue(32'h0001_0000, 32'h0, 4'h1, 1'b0, 2'b00, 32'h0001_0000, 1'b1, {1'b1, 32'h0});
      err_cycle();
      issue(32'h0200_000F, 32'h0, 4'h0, 1'b1, 2'b10, 32'h0000_000F, 1'b1, {1'b0, 32'h3333_4444});
      respond(1, 32'h3333_4444);
      issue(32'h0200_0010, 32'h0, 4'h0, 1'b0, 2'b00, 32'h0200_0010, 1'b1, {1'b1, 32'h0});
      err_cycle();
      issue(32'h01FF_FFFF, 32'h0, 4'h0, 1'b0, 2'b00, 32'h01FF_FFFF, 1'b1, {1'b1, 32'h0});
      err_cycle();

      // Non-selected slave ready ignored while BUSY
      issue(32'h0000_0100, 32'h0, 4'h0, 1'b0, 2'b01, 32'h100, 1'b1, {1'b0, 32'h0BAD_F00D});
      slv_rdata[63:32] = 32'h7777_7777;
      slv_ready = 2'b10;
      @(negedge clock);
      chk("other_ready_ignored", 64'(memory_ready), 64'd0);
      step();
      slv_ready = '0;
      respond(0, 32'h0BAD_F00D);

      // Stale ready in IDLE dropped
      slv_ready = 2'b11;
      @(negedge clock);
      chk("idle_ready_ignored", 64'(memory_ready), 64'd0);
      step();
      slv_ready = '0;

      // Reset in the middle of a transaction
      issue(32'h0000_0200, 32'h0, 4'h0, 1'b0, 2'b01, 32'h200, 1'b0, 33'h0);
      reset        = 1'b0;
      memory_valid = 1'b1;
      memory_addr  = 32'h0200_0000;
      slv_ready    = 2'b01;
      @(negedge clock);
      chk("midrst_slv_valid", 64'(slv_valid), 64'd0);
      chk("midrst_ready", 64'(memory_ready), 64'd0);
      chk("midrst_state", 64'(dbg_state), 64'd0);
      step();
      memory_valid = 1'b0;
      reset        = 1'b1;
      @(negedge clock);
      chk("post_rst_late_ready", 64'(memory_ready), 64'd0);
      step();
      slv_ready = '0;
      issue(32'h0200_0008, 32'h0, 4'h0, 1'b0, 2'b10, 32'h8, 1'b1, {1'b0, 32'h9999_0000});
      respond(1, 32'h9999_0000);

`ifdef BUS_ROUTER_TIMEOUT_EN
      // Slave0 never answers: error response exactly 8 cycles after the request
      issue(32'h0000_0300, 32'h0, 4'h0, 1'b0, 2'b01, 32'h300, 1'b1, {1'b1, 32'h0});
      for (int k = 1; k <= 8; k++) begin
         @(negedge clock);
         chk("timeout_cycle", 64'(memory_ready), (k == 8) ? 64'd1 : 64'd0);
         step();
      end
      slv_ready = 2'b01;
      @(negedge clock);
      chk("timeout_late_ready", 64'(memory_ready), 64'd0);
      step();
      slv_ready = '0;
`endif

      repeat (3) step();
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
